// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of DMem. Port A (CPU load/store) has fixed
// priority. Port B (boot loader / debug DMA) is granted when it is the only
// requester, or after STARVE_LIMIT consecutive A grants while B was waiting.
// DMem read data arrives one cycle after the access. The in-flight read is
// tracked so that its data and load-extension code go back to the right port.
module dmem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_W        = 3
) (
   input  logic        clk,
   input  logic        rstn,

   input  logic        a_req,
   input  logic [3:0]  a_we,
   input  logic [2:0]  a_load_select,
   input  logic [31:0] a_addr,
   input  logic [31:0] a_wdata,
   output logic        a_gnt,
   output logic        a_rvalid,
   output logic [31:0] a_rdata,

   input  logic        b_req,
   input  logic [3:0]  b_we,
   input  logic [2:0]  b_load_select,
   input  logic [31:0] b_addr,
   input  logic [31:0] b_wdata,
   output logic        b_gnt,
   output logic        b_rvalid,
   output logic [31:0] b_rdata,

   output logic        mem_rd,
   output logic [3:0]  mem_we,
   output logic [2:0]  mem_load_select,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,

   output logic        busy
);

   typedef enum logic {
      OWN_A = 1'b0,
      OWN_B = 1'b1
   } owner_t;

   logic [CNT_W-1:0] starve_cnt;
   logic             starved;
   logic             rsp_valid;
   owner_t           rsp_owner;
   logic [2:0]       rsp_lsel;

   assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

   // Grant decision: A wins contention unless B has waited out the limit.
   always_comb begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
      if (rstn) begin
         if (a_req && !(b_req && starved)) begin
            a_gnt = 1'b1;
         end else if (b_req) begin
            b_gnt = 1'b1;
         end
      end
   end

   // Route the granted port's access onto the DMem interface.
   always_comb begin
      mem_we    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (a_gnt) begin
         mem_we    = a_we;
         mem_addr  = a_addr;
         mem_wdata = a_wdata;
      end else if (b_gnt) begin
         mem_we    = b_we;
         mem_addr  = b_addr;
         mem_wdata = b_wdata;
      end
   end

   assign mem_rd = a_gnt | b_gnt;

   // Count A grants that B had to sit through; any B grant or idle B clears it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         starve_cnt <= '0;
      end else if (b_gnt || !b_req) begin
         starve_cnt <= '0;
      end else if (a_gnt && !starved) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

   // Remember who owns the read whose data DMem returns next cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rsp_valid <= 1'b0;
         rsp_owner <= OWN_A;
         rsp_lsel  <= '0;
      end else if (a_gnt && (a_we == '0)) begin
         rsp_valid <= 1'b1;
         rsp_owner <= OWN_A;
         rsp_lsel  <= a_load_select;
      end else if (b_gnt && (b_we == '0)) begin
         rsp_valid <= 1'b1;
         rsp_owner <= OWN_B;
         rsp_lsel  <= b_load_select;
      end else begin
         rsp_valid <= 1'b0;
      end
   end

   // DMem extends its registered word combinationally, so it must see the
   // code of the read being returned, not of the access issued this cycle.
   assign mem_load_select = rsp_lsel;

   assign a_rvalid = rsp_valid && (rsp_owner == OWN_A);
   assign b_rvalid = rsp_valid && (rsp_owner == OWN_B);
   assign a_rdata  = mem_rdata;
   assign b_rdata  = mem_rdata;
   assign busy     = rsp_valid;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a DMem environment model, a transaction-level
// reference (grant rule, golden memory, response queue) checked every cycle,
// and directed scenarios with hand-computed literal expectations.
module tb_dmem_arbiter;

   localparam int unsigned LIMIT     = 4;
   localparam logic [2:0]  LS_B      = 3'b000;
   localparam logic [2:0]  LS_H      = 3'b001;
   localparam logic [2:0]  LS_W      = 3'b010;
   localparam logic [2:0]  LS_BU     = 3'b100;
   localparam logic [2:0]  LS_HU     = 3'b101;
   localparam logic [31:0] ANVAY_ADR = 32'h0010_0000;
   localparam logic [31:0] LED_ADR   = 32'h0010_0014;
   localparam logic [31:0] ANVAY     = 32'h013A_1E3F;

   logic        clk = 1'b0;
   logic        rstn;
   logic        a_req, b_req;
   logic [3:0]  a_we, b_we;
   logic [2:0]  a_load_select, b_load_select;
   logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
   logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
   logic [31:0] a_rdata, b_rdata;
   logic        mem_rd;
   logic [3:0]  mem_we;
   logic [2:0]  mem_load_select;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        busy;

   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
      .clk(clk), .rstn(rstn),
      .a_req(a_req), .a_we(a_we), .a_load_select(a_load_select),
      .a_addr(a_addr), .a_wdata(a_wdata), .a_gnt(a_gnt),
      .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_load_select(b_load_select),
      .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt),
      .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .mem_rd(mem_rd), .mem_we(mem_we), .mem_load_select(mem_load_select),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   // Load extension as DMem applies it to a word and byte offset.
   function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] ls,
                                       input logic [1:0] off);
      logic [31:0] s;
      s = w >> {off, 3'b000};
      case (ls)
         LS_B:    return {{24{s[7]}}, s[7:0]};
         LS_H:    return {{16{s[15]}}, s[15:0]};
         LS_BU:   return {24'h0, s[7:0]};
         LS_HU:   return {16'h0, s[15:0]};
         default: return w;
      endcase
   endfunction

   // ---------------- DMem environment ----------------
   logic [31:0] env_ram [256];
   logic [31:0] env_led;
   logic [31:0] env_raw;
   logic [1:0]  env_off;

   function automatic logic [31:0] env_read(input logic [31:0] ad);
      if (ad[31:2] == ANVAY_ADR[31:2]) return ANVAY;
      if (ad[31:2] == LED_ADR[31:2])   return env_led;
      return env_ram[ad[9:2]];
   endfunction

   always @(posedge clk) begin
      if (mem_rd) begin
         for (int k = 0; k < 4; k++) begin
            if (mem_we[k]) begin
               if (mem_addr[31:2] == LED_ADR[31:2])
                  env_led[8*k +: 8] <= mem_wdata[8*k +: 8];
               else if (mem_addr[31:2] != ANVAY_ADR[31:2])
                  env_ram[mem_addr[9:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
            end
         end
         env_raw <= env_read(mem_addr);
         env_off <= mem_addr[1:0];
      end
   end

   assign mem_rdata = ext(env_raw, mem_load_select, env_off);

   // ---------------- reference model ----------------
   typedef struct {
      int unsigned due;
      bit          owner_b;
      logic [31:0] data;
      logic [2:0]  ls;
   } rsp_t;

   rsp_t        q[$];
   logic [31:0] gold_ram [256];
   logic [31:0] gold_led;
   int unsigned wins = 0;
   int unsigned cyc  = 0;
   bit          ea = 1'b0, eb = 1'b0;

   function automatic logic [31:0] gold_read(input logic [31:0] ad);
      if (ad[31:2] == ANVAY_ADR[31:2]) return ANVAY;
      if (ad[31:2] == LED_ADR[31:2])   return gold_led;
      return gold_ram[ad[9:2]];
   endfunction

   task automatic gold_write(input logic [31:0] ad, input logic [3:0] we,
                             input logic [31:0] wd);
      for (int k = 0; k < 4; k++) begin
         if (we[k]) begin
            if (ad[31:2] == LED_ADR[31:2]) gold_led[8*k +: 8] = wd[8*k +: 8];
            else if (ad[31:2] != ANVAY_ADR[31:2]) gold_ram[ad[9:2]][8*k +: 8] = wd[8*k +: 8];
         end
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
      end
   endtask

   // Apply each accepted access to the golden memory and log expected reads.
   initial begin
      rsp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         if (!rstn) begin
            wins = 0;
            q.delete();
         end else begin
            if (ea) begin
               if (a_we != 4'h0) gold_write(a_addr, a_we, a_wdata);
               else begin
                  e.due = cyc; e.owner_b = 1'b0; e.ls = a_load_select;
                  e.data = ext(gold_read(a_addr), a_load_select, a_addr[1:0]);
                  q.push_back(e);
               end
            end else if (eb) begin
               if (b_we != 4'h0) gold_write(b_addr, b_we, b_wdata);
               else begin
                  e.due = cyc; e.owner_b = 1'b1; e.ls = b_load_select;
                  e.data = ext(gold_read(b_addr), b_load_select, b_addr[1:0]);
                  q.push_back(e);
               end
            end
            if (eb || !b_req) wins = 0;
            else if (ea) wins++;
         end
      end
   end

   // Every cycle: compare grants, DMem drive and responses with the model.
   always @(negedge clk) begin
      logic        rva, rvb;
      logic [31:0] xa, xw;
      logic [3:0]  xwe;
      if (!rstn) q.delete();
      ea = rstn && a_req && !(b_req && wins >= LIMIT);
      eb = rstn && b_req && !ea;
      xa  = ea ? a_addr  : (eb ? b_addr  : 32'h0);
      xw  = ea ? a_wdata : (eb ? b_wdata : 32'h0);
      xwe = ea ? a_we    : (eb ? b_we    : 4'h0);
      chk1("a_gnt", a_gnt, ea);
      chk1("b_gnt", b_gnt, eb);
      chk1("mem_rd", mem_rd, ea | eb);
      chk32("mem_addr", mem_addr, xa);
      chk32("mem_wdata", mem_wdata, xw);
      chk32("mem_we", {28'h0, mem_we}, {28'h0, xwe});
      rva = 1'b0;
      rvb = 1'b0;
      while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
      if (q.size() > 0 && q[0].due == cyc) begin
         rva = !q[0].owner_b;
         rvb = q[0].owner_b;
         chk32(rvb ? "b_rdata" : "a_rdata", rvb ? b_rdata : a_rdata, q[0].data);
         chk32("mem_load_select", {29'h0, mem_load_select}, {29'h0, q[0].ls});
         void'(q.pop_front());
      end
      chk1("a_rvalid", a_rvalid, rva);
      chk1("b_rvalid", b_rvalid, rvb);
      chk1("busy", busy, rva | rvb);
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(input logic r, input logic [3:0] we, input logic [2:0] ls,
                        input logic [31:0] ad, input logic [31:0] wd);
      a_req = r; a_we = we; a_load_select = ls; a_addr = ad; a_wdata = wd;
   endtask

   task automatic set_b(input logic r, input logic [3:0] we, input logic [2:0] ls,
                        input logic [31:0] ad, input logic [31:0] wd);
      b_req = r; b_we = we; b_load_select = ls; b_addr = ad; b_wdata = wd;
   endtask

   initial begin
      rstn = 1'b0;
      set_a(1'b1, 4'h0, LS_W, 32'h10, 32'h0);
      set_b(1'b0, 4'h0, LS_W, 32'h0, 32'h0);
      for (int i = 0; i < 256; i++) begin
         env_ram[i]  <= 32'h1000_0000 + 32'(i);
         gold_ram[i]  = 32'h1000_0000 + 32'(i);
      end
      env_ram[4] <= 32'hDEAD_BEEF; gold_ram[4] = 32'hDEAD_BEEF;
      env_ram[8] <= 32'h0000_00F0; gold_ram[8] = 32'h0000_00F0;
      env_led    <= 32'h0;         gold_led    = 32'h0;
      env_raw    <= 32'h0;
      env_off    <= 2'b00;

      // Held in reset with A requesting: nothing granted, nothing pending.
      repeat (2) @(negedge clk);
      chk1("rst_a_gnt", a_gnt, 1'b0);
      chk1("rst_mem_rd", mem_rd, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      tick();
      rstn = 1'b1;
      set_a(1'b0, 4'h0, LS_W, 32'h0, 32'h0);

      // A word read of ram[4].
      tick();
      set_a(1'b1, 4'h0, LS_W, 32'h10, 32'h0);
      @(negedge clk); chk1("t1_a_gnt", a_gnt, 1'b1);
      tick();
      set_a(1'b0, 4'h0, LS_W, 32'h0, 32'h0);
      @(negedge clk);
      chk1("t1_a_rvalid", a_rvalid, 1'b1);
      chk32("t1_a_rdata", a_rdata, 32'hDEAD_BEEF);
      chk1("t1_b_rvalid", b_rvalid, 1'b0);
      chk32("t1_lsel", {29'h0, mem_load_select}, {29'h0, LS_W});

      // B half-word write to LED, then A reads it back.
      tick();
      set_b(1'b1, 4'b0011, LS_W, LED_ADR, 32'h0000_A5A5);
      @(negedge clk); chk1("t2_b_gnt", b_gnt, 1'b1);
      tick();
      set_b(1'b0, 4'h0, LS_W, 32'h0, 32'h0);
      set_a(1'b1, 4'h0, LS_W, LED_ADR, 32'h0);
      tick();
      set_a(1'b0, 4'h0, LS_W, 32'h0, 32'h0);
      @(negedge clk);
      chk32("t2_led", env_led, 32'h0000_A5A5);
      chk1("t2_a_rvalid", a_rvalid, 1'b1);
      chk32("t2_a_rdata", a_rdata, 32'h0000_A5A5);

      // Continuous contention: A,A,A,A,B repeating.
      tick();
      set_a(1'b1, 4'h0, LS_W, 32'h0, 32'h0);
      set_b(1'b1, 4'h0, LS_W, ANVAY_ADR, 32'h0);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         chk1("t3_b_gnt", b_gnt, (i % 5) == 4);
         if (i > 0 && (i % 5) == 0) begin
            chk1("t3_b_rvalid", b_rvalid, 1'b1);
            chk32("t3_b_rdata", b_rdata, ANVAY);
         end
         tick();
      end

      // B withdraws mid-streak: its wait count restarts.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); chk1("t3w_a_gnt", a_gnt, 1'b1);
         tick();
      end
      b_req = 1'b0;
      @(negedge clk); chk1("t3w_solo", a_gnt, 1'b1);
      tick();
      b_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); chk1("t3w_b_gnt", b_gnt, i == 4);
         tick();
      end
      set_a(1'b0, 4'h0, LS_W, 32'h0, 32'h0);
      set_b(1'b0, 4'h0, LS_W, 32'h0, 32'h0);
      repeat (2) tick();

      // Signed byte load then word load of the same address.
      set_a(1'b1, 4'h0, LS_B, 32'h20, 32'h0);
      @(negedge clk); chk1("t4_a_gnt", a_gnt, 1'b1);
      tick();
      set_a(1'b1, 4'h0, LS_W, 32'h20, 32'h0);
      @(negedge clk);
      chk32("t4_byte", a_rdata, 32'hFFFF_FFF0);
      chk32("t4_lsel_b", {29'h0, mem_load_select}, {29'h0, LS_B});
      tick();
      set_a(1'b0, 4'h0, LS_W, 32'h0, 32'h0);
      @(negedge clk);
      chk32("t4_word", a_rdata, 32'h0000_00F0);
      chk32("t4_lsel_w", {29'h0, mem_load_select}, {29'h0, LS_W});
      tick();

      // Reset right after an A read grant kills the response.
      set_a(1'b1, 4'h0, LS_W, 32'h10, 32'h0);
      @(negedge clk); chk1("t5_a_gnt", a_gnt, 1'b1);
      tick();
      rstn = 1'b0;
      #1;
      chk1("t5_a_rvalid", a_rvalid, 1'b0);
      chk1("t5_busy", busy, 1'b0);
      @(negedge clk);
      chk1("t5_gnt_in_rst", a_gnt, 1'b0);
      tick();
      tick();
      set_a(1'b0, 4'h0, LS_W, 32'h0, 32'h0);
      set_b(1'b1, 4'h0, LS_W, 32'h4, 32'h0);
      rstn = 1'b1;
      @(negedge clk); chk1("t5_b_first", b_gnt, 1'b1);
      tick();
      set_b(1'b0, 4'h0, LS_W, 32'h0, 32'h0);
      @(negedge clk); chk1("t5_b_rvalid", b_rvalid, 1'b1);
      tick();

      // B write then B read of the same word, back to back.
      set_b(1'b1, 4'hF, LS_W, 32'h4, 32'h1234_5678);
      @(negedge clk); chk1("t6_wr_gnt", b_gnt, 1'b1);
      tick();
      set_b(1'b1, 4'h0, LS_W, 32'h4, 32'h0);
      @(negedge clk);
      chk1("t6_rd_gnt", b_gnt, 1'b1);
      chk1("t6_no_wr_rsp", b_rvalid, 1'b0);
      tick();
      set_b(1'b0, 4'h0, LS_W, 32'h0, 32'h0);
      @(negedge clk);
      chk1("t6_b_rvalid", b_rvalid, 1'b1);
      chk32("t6_b_rdata", b_rdata, 32'h1234_5678);
      tick();
      @(negedge clk); chk1("t6_rvalid_once", b_rvalid, 1'b0);
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
